// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the stream source / memory model on the master side.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        write_en;
    logic [9:0]  write_addr;
    logic [31:0] write_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, write_en, write_addr, write_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, write_en, write_addr, write_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words and writes them to imem.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and the err flag.
module imem_loader #(
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [10:0]   word_count,
    input  logic          abort,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CSUM, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
`endif

    localparam logic [9:0] BASE = 10'(BASE_ADDR % 1024);

    state_t      state, state_next;
    logic [10:0] count_q, index_q;
    logic [1:0]  lane_q;
    logic [23:0] part_q;
    logic        write_en_q;
    logic [9:0]  write_addr_q;
    logic [31:0] write_data_q;
    logic        in_ready_d;
    logic        load_go;
    logic        accept;
    logic        last_word;
    logic [10:0] count_clip;

    assign count_clip = (word_count > 11'd1024) ? 11'd1024 : word_count;
    assign accept     = bus.in_valid && in_ready_d;
    assign last_word  = (index_q + 11'd1) == count_q;

    assign bus.in_ready   = in_ready_d;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;

    // Handshake and status flags are pure state decodes, so they are all 0 in IDLE after reset.
    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready_d = (state == ST_LOAD) || (state == ST_CSUM);
`else
        in_ready_d = (state == ST_LOAD);
`endif
        busy = in_ready_d;
        done = (state == ST_DONE);
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_go = 1'b1;
                    if (count_clip != 11'd0) begin
                        state_next = ST_LOAD;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_DONE;
`endif
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (accept && lane_q == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (accept) begin
                    state_next = ST_DONE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 8'd0;
            err_q  <= 1'b0;
        end else if (load_go) begin
            csum_q <= 8'd0;
            err_q  <= 1'b0;
        end else if (state == ST_LOAD && accept && !abort) begin
            csum_q <= csum_q ^ bus.in_data;
        end else if (state == ST_CSUM && accept && !abort) begin
            err_q <= (csum_q != bus.in_data);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Word assembly: lanes 0..2 are buffered, the lane-3 byte completes the write directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= 11'd0;
            index_q      <= 11'd0;
            lane_q       <= 2'd0;
            part_q       <= 24'd0;
            write_en_q   <= 1'b0;
            write_addr_q <= 10'd0;
            write_data_q <= 32'd0;
        end else begin
            write_en_q <= 1'b0;
            if (load_go) begin
                count_q <= count_clip;
                index_q <= 11'd0;
                lane_q  <= 2'd0;
            end else if (state == ST_LOAD && abort) begin
                lane_q <= 2'd0;
            end else if (state == ST_LOAD && accept) begin
                if (lane_q == 2'd3) begin
                    write_en_q   <= 1'b1;
                    write_addr_q <= BASE + index_q[9:0];
                    write_data_q <= {bus.in_data, part_q};
                    index_q      <= index_q + 11'd1;
                    lane_q       <= 2'd0;
                end else begin
                    case (lane_q)
                        2'd0:    part_q[7:0]   <= bus.in_data;
                        2'd1:    part_q[15:8]  <= bus.in_data;
                        default: part_q[23:16] <= bus.in_data;
                    endcase
                    lane_q <= lane_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; two instances (BASE_ADDR 0 and 1023) run in lockstep.
// Expected words/addresses/err come from the byte list with plain arithmetic.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [10:0] word_count;
    logic        busy0, done0, err0, busy1, done1, err1;

    imem_loader_if bus0 ();
    imem_loader_if bus1 ();

    imem_loader #(.BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count), .abort(abort),
        .bus(bus0.slave), .busy(busy0), .done(done0), .err(err0)
    );

    imem_loader #(.BASE_ADDR(1023)) dut1 (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count), .abort(abort),
        .bus(bus1.slave), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  stim[$];
    logic [41:0] obs0[$], obs1[$];

    always @(negedge clk) begin
        if (bus0.write_en) obs0.push_back({bus0.write_addr, bus0.write_data});
        if (bus1.write_en) obs1.push_back({bus1.write_addr, bus1.write_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stream(input logic v, input logic [7:0] d);
        bus0.in_valid = v;
        bus0.in_data  = d;
        bus1.in_valid = v;
        bus1.in_data  = d;
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic bsy,
                                input logic dn, input logic we);
        check({tag, ".in_ready0"}, bus0.in_ready, rdy);
        check({tag, ".in_ready1"}, bus1.in_ready, rdy);
        check({tag, ".busy0"}, busy0, bsy);
        check({tag, ".busy1"}, busy1, bsy);
        check({tag, ".done0"}, done0, dn);
        check({tag, ".done1"}, done1, dn);
        check({tag, ".write_en0"}, bus0.write_en, we);
        check({tag, ".write_en1"}, bus1.write_en, we);
    endtask

    task automatic check_reset(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".write_addr0"}, bus0.write_addr, 0);
        check({tag, ".write_addr1"}, bus1.write_addr, 0);
        check({tag, ".write_data0"}, bus0.write_data, 0);
        check({tag, ".write_data1"}, bus1.write_data, 0);
        check({tag, ".err0"}, err0, 0);
        check({tag, ".err1"}, err1, 0);
    endtask

    function automatic logic [31:0] exp_word(input int w);
        return {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
    endfunction

    function automatic logic [9:0] exp_addr(input int base, input int w);
        return 10'((base + w) % 1024);
    endfunction

    function automatic logic [7:0] stim_xor();
        logic [7:0] x = 8'h00;
        foreach (stim[i]) x ^= stim[i];
        return x;
    endfunction

    task automatic fill_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        bit   accepted = 1'b0;
        drive_stream(1'b0, 8'h00);
        repeat (gap) tick;
        drive_stream(1'b1, b);
        for (int k = 0; k < 16 && !accepted; k++) begin
            r = bus0.in_ready;
            tick;
            accepted = r;
        end
        drive_stream(1'b0, 8'h00);
        if (!accepted) check("byte_accepted", 64'(accepted), 1);
    endtask

    task automatic do_start(input int wc);
        start      = 1'b1;
        word_count = 11'(wc);
        tick;
        start      = 1'b0;
    endtask

    task automatic check_words(input string tag, input int nw);
        check({tag, ".writes0"}, obs0.size(), nw);
        check({tag, ".writes1"}, obs1.size(), nw);
        for (int w = 0; w < nw && w < obs0.size() && w < obs1.size(); w++) begin
            check({tag, ".word0"}, obs0[w], {exp_addr(0, w), exp_word(w)});
            check({tag, ".word1"}, obs1[w], {exp_addr(1023, w), exp_word(w)});
        end
    endtask

    task automatic run_load(input int wc, input int gmin, input int gmax,
                            input logic [7:0] csum_byte, input bit poke);
        int nw = (wc > 1024) ? 1024 : wc;
        logic exp_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = (stim_xor() != csum_byte);
`else
        exp_err = 1'b0;
`endif
        obs0.delete();
        obs1.delete();
        do_start(wc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_status("start", 1'b1, 1'b1, 1'b0, 1'b0);
`else
        if (nw == 0) check_status("start_zero", 1'b0, 1'b0, 1'b1, 1'b0);
        else         check_status("start", 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        for (int i = 0; i < nw * 4; i++) begin
            if (poke && i == 1) begin
                start      = 1'b1;
                word_count = 11'd7;
                tick;
                start      = 1'b0;
            end
            send_byte(stim[i], $urandom_range(gmax, gmin));
            if (i % 4 == 3) begin
                check("lat.write_addr0", bus0.write_addr, exp_addr(0, i / 4));
                check("lat.write_addr1", bus1.write_addr, exp_addr(1023, i / 4));
                check("lat.write_data0", bus0.write_data, exp_word(i / 4));
                check("lat.write_data1", bus1.write_data, exp_word(i / 4));
                if (i == nw * 4 - 1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    check_status("last_word", 1'b1, 1'b1, 1'b0, 1'b1);
`else
                    check_status("last_word", 1'b0, 1'b0, 1'b1, 1'b1);
`endif
                end else begin
                    check_status("word", 1'b1, 1'b1, 1'b0, 1'b1);
                end
            end else begin
                check_status("byte", 1'b1, 1'b1, 1'b0, 1'b0);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_byte, gmin);
        check_status("csum_done", 1'b0, 1'b0, 1'b1, 1'b0);
`else
        // A trailing byte after the image must not be taken.
        drive_stream(1'b1, csum_byte);
        tick;
        drive_stream(1'b0, 8'h00);
        check_status("extra_byte", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        check("err0", err0, exp_err);
        check("err1", err1, exp_err);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_in_done0", done0, 1);
        check("abort_in_done1", done1, 1);
        check("err_held0", err0, exp_err);
        check_words("load", nw);
    endtask

    task automatic abort_after(input int k);
        fill_stim(12);
        obs0.delete();
        obs1.delete();
        do_start(3);
        for (int i = 0; i < k; i++) send_byte(stim[i], 0);
        drive_stream(1'b1, stim[k]);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        drive_stream(1'b0, 8'h00);
        check_status("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check_status("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check_words("abort", k / 4);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        word_count = 11'd0;
        drive_stream(1'b0, 8'h00);
        repeat (3) tick;
        check_reset("reset");
        rst = 1'b0;
        tick;

        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 0, 0, stim_xor(), 1'b0);

        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 1, 1, stim_xor(), 1'b0);

        abort_after(6);
        abort_after(7);

        fill_stim(8);
        do_start(2);
        for (int i = 0; i < 5; i++) send_byte(stim[i], 0);
        drive_stream(1'b1, stim[5]);
        rst = 1'b1;
        tick;
        check_reset("mid_rst");
        rst = 1'b0;
        drive_stream(1'b0, 8'h00);
        tick;
        fill_stim(8);
        run_load(2, 0, 1, stim_xor(), 1'b0);

        stim = '{8'h11, 8'h22, 8'h44, 8'h88};
        run_load(1, 0, 0, 8'hFF, 1'b0);
        run_load(1, 0, 0, 8'h00, 1'b0);
        stim.delete();
        run_load(0, 0, 0, 8'h00, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int wc = $urandom_range(6, 1);
            fill_stim(wc * 4);
            run_load(wc, 0, 2, (r % 2 == 1) ? stim_xor() : 8'($urandom), r[0]);
        end

        fill_stim(4096);
        run_load(1100, 0, 0, stim_xor(), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that fills the 1024 x 32-bit instruction memory through its write port. A byte stream (from the debug UART or host bridge) arrives over a valid/ready handshake. The loader assembles little-endian 32-bit words and issues one registered write per word at consecutive word addresses. It reports busy/done status, so the core is held until the program image is complete.

## Interface
- `BASE_ADDR`, default 0: word address of the first write; increments wrap modulo 1024.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle load request; sampled in IDLE or DONE only.
- `word_count`  in  11  number of words to load; sampled with `start`; values >1024 clip to 1024.
- `abort`  in  1  cancels an active load.
- `in_valid`  in  1  byte present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `write_en`  out  1  one-cycle write strobe to instruction memory.
- `write_addr`  out  10  word address.
- `write_data`  out  32  assembled word.
- `busy`  out  1  a load is in progress (LOAD or CSUM state).
- `done`  out  1  load completed; held until the next `start` or `rst`.
- `err`  out  1  checksum mismatch; valid while `done` is high (see Configuration).

## Operation
- States: IDLE, LOAD, CSUM (only with the macro), DONE.
- IDLE/DONE + `start`: latch count; word index = 0; byte lane = 0; clear `done`/`err`.
  - Count ≠ 0: go to LOAD.
  - Count = 0: go to CSUM if enabled, else DONE with no writes.
- `in_ready` = 1 in LOAD and CSUM, else 0, decoded directly from state.
- A byte is accepted when `in_valid && in_ready`.
- Lane 0 fills bits [7:0], lane 1 [15:8], lane 2 [23:16], lane 3 [31:24].
- On lane-3 acceptance:
  - Register `write_en` = 1, `write_addr` = (BASE_ADDR + index) mod 1024, `write_data` = {b3,b2,b1,b0}.
  - Increment index; reset lane to 0.
- The final word's lane-3 acceptance moves the state to CSUM (enabled) or DONE.
- `abort` in LOAD/CSUM: return to IDLE. The partial word is discarded with no write. Writes already issued stand. `done` stays 0.
- `start` while busy is ignored. `abort` outside LOAD/CSUM is ignored. `abort` has priority over a byte accepted in the same cycle.
- `rst`: state IDLE.
  - All outputs 0: `in_ready`, `write_en`, `write_addr`, `write_data`, `busy`, `done`, `err`.
  - Lane, index and checksum registers are 0.
  - A reset mid-load discards the load.

## Timing
- Sustains one byte per cycle; one write every 4 accepted bytes.
- Write latency: lane-3 byte accepted in cycle N → `write_en` high in cycle N+1 only.
- Last-word acceptance in cycle N (macro off): `done` = 1 and `busy` = 0 from cycle N+1, coincident with the final `write_en`.
  - `in_ready` falls in N+1; no extra byte is accepted.
- `start` in cycle N → `busy` = 1 and `in_ready` = 1 from cycle N+1.
- `in_valid` gaps stall assembly without penalty; lane state is retained.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running XOR of all accepted data bytes is kept (cleared at `start`).
  - After the last word, state CSUM accepts exactly one checksum byte.
  - Acceptance in cycle N → DONE in N+1, with `err` = (running XOR ≠ byte).
- Undefined:
  - CSUM state, XOR register and checksum compare are absent.
  - `err` is tied to 0.
  - LOAD → DONE directly.

## Test plan
- Reset, then `start`, `word_count`=2, bytes 78 56 34 12 EF BE AD DE back-to-back.
  - Expect write_en at addr 0 with data 0x12345678, then addr 1 with 0xDEADBEEF.
  - `done` high in the cycle of the second write; exactly 2 writes total.
- `in_valid` toggled every other cycle, `word_count`=1, bytes 01 02 03 04.
  - Expect a single write of 0x04030201, issued one cycle after byte 04 is accepted.
- BASE_ADDR=1023, `word_count`=2.
  - Expect writes at addr 1023, then 0 (wrap).
- `abort` after 6 bytes of a 3-word load.
  - Expect only one write (word 0), `done`=0, state IDLE, `in_ready`=0 next cycle.
- `rst` asserted mid-word.
  - Expect all outputs 0 next cycle; a new `start` loads from index 0 with lane 0.
- Checksum on, `word_count`=1, bytes 11 22 44 88, then checksum byte FF.
  - Expect `err`=0; repeating with checksum byte 00 gives `err`=1.
  - `word_count`=0 with checksum byte 00 gives `done`=1, `err`=0, no writes.
